// File: rtl/fb_pkg.sv
// Shared state encoding and sizing helper for the framebuffer writer.
package fb_pkg;

   typedef enum logic [2:0] {
      StRun        = 3'd0,
      StDrain      = 3'd1,
      StSwap       = 3'd2,
      StClearDrain = 3'd3,
      StClear      = 3'd4
   } fb_state_e;

   function automatic int unsigned fb_pixels(input int unsigned width, input int unsigned height);
      return width * height;
   endfunction

endpackage

// File: rtl/fb_fifo.sv
// Synchronous first-word-fall-through FIFO: rdata_o presents the head entry whenever not empty.
module fb_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PtrW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PtrW+1)'(1);
         2'b01:   count_d = count_q - (PtrW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once pushed.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel-store stage: clips pixels, queues writes, issues them to memory and rotates frame buffers.
// Define FB_CLEAR_EN to add the back-buffer clear command (i_clear_req/i_clear_color/o_clear_done).
module framebuffer_writer
   import fb_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH  = 640,
   parameter int unsigned SCREEN_HEIGHT = 480,
   parameter int unsigned COLOR_WIDTH   = 32,
   parameter int unsigned COORD_WIDTH   = 10,
   parameter int unsigned NUM_BUFFERS   = 2,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 20
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_pix_valid,
   output logic                           o_pix_ready,
   input  logic [COORD_WIDTH-1:0]         i_pix_x,
   input  logic [COORD_WIDTH-1:0]         i_pix_y,
   input  logic [COLOR_WIDTH-1:0]         i_pix_color,
   input  logic                           i_swap_req,
   output logic                           o_swap_done,
   output logic [$clog2(NUM_BUFFERS)-1:0] o_front_idx,
   output logic                           o_mem_req,
   input  logic                           i_mem_gnt,
   output logic [ADDR_WIDTH-1:0]          o_mem_addr,
   output logic [COLOR_WIDTH-1:0]         o_mem_wdata,
`ifdef FB_CLEAR_EN
   input  logic                           i_clear_req,
   input  logic [COLOR_WIDTH-1:0]         i_clear_color,
   output logic                           o_clear_done,
`endif
   output logic                           o_busy,
   output logic [15:0]                    o_drop_count
);

   localparam int unsigned PIXELS = fb_pixels(SCREEN_WIDTH, SCREEN_HEIGHT);
   localparam int unsigned IDX_W  = $clog2(NUM_BUFFERS);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  addr;
      logic [COLOR_WIDTH-1:0] color;
   } fb_entry_t;

   fb_state_e        state_q, state_d;
   logic [IDX_W-1:0] front_q, front_d;
   logic [IDX_W-1:0] back_q, back_d;
   logic [IDX_W-1:0] next_back;
   logic             pend_q, pend_d;
   logic [15:0]      drop_q, drop_d;

   logic [ADDR_WIDTH-1:0] back_base;
   logic [ADDR_WIDTH-1:0] pix_addr;
   logic                  pix_clip;
   logic                  accept;

   fb_entry_t        push_entry;
   fb_entry_t        head;
   logic             fifo_push, fifo_pop;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;

`ifdef FB_CLEAR_EN
   logic [COLOR_WIDTH-1:0] clr_color_q, clr_color_d;
   logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
   logic                   clr_done_q, clr_done_d;
`endif

   // Address and clip decision are taken at acceptance against the current back buffer.
   always_comb begin
      back_base = ADDR_WIDTH'(back_q) * ADDR_WIDTH'(PIXELS);
      pix_addr  = back_base + ADDR_WIDTH'(i_pix_y) * ADDR_WIDTH'(SCREEN_WIDTH)
                  + ADDR_WIDTH'(i_pix_x);
      pix_clip  = (32'(i_pix_x) >= SCREEN_WIDTH) || (32'(i_pix_y) >= SCREEN_HEIGHT);
      next_back = (back_q == IDX_W'(NUM_BUFFERS - 1)) ? '0 : back_q + IDX_W'(1);
   end

   // Ready depends only on registered state, never on the grant.
   assign o_pix_ready = !rst && (state_q == StRun) && !fifo_full;
   assign accept      = i_pix_valid && o_pix_ready;
   assign fifo_push   = accept && !pix_clip;
   assign fifo_pop    = !fifo_empty && i_mem_gnt;

   always_comb begin
      push_entry.addr  = pix_addr;
      push_entry.color = i_pix_color;
   end

   fb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fb_entry_t))
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (fifo_push),
      .wdata_i (push_entry),
      .pop_i   (fifo_pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      front_d = front_q;
      back_d  = back_q;
      pend_d  = pend_q;
      drop_d  = drop_q;
`ifdef FB_CLEAR_EN
      clr_color_d = clr_color_q;
      clr_cnt_d   = clr_cnt_q;
      clr_done_d  = 1'b0;
`endif

      if (accept && pix_clip && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end

      case (state_q)
         StRun: begin
`ifdef FB_CLEAR_EN
            if (i_clear_req) begin
               // Clear wins a tie; a simultaneous swap waits behind it.
               state_d     = StClearDrain;
               clr_color_d = i_clear_color;
               clr_cnt_d   = '0;
               if (i_swap_req) begin
                  pend_d = 1'b1;
               end
            end else
`endif
            if (i_swap_req || pend_q) begin
               state_d = StDrain;
               pend_d  = 1'b0;
            end
         end
         StDrain: begin
            if (i_swap_req) begin
               pend_d = 1'b1;
            end
            if (fifo_empty) begin
               state_d = StSwap;
            end
         end
         StSwap: begin
            if (i_swap_req) begin
               pend_d = 1'b1;
            end
            front_d = back_q;
            back_d  = next_back;
            state_d = StRun;
         end
`ifdef FB_CLEAR_EN
         StClearDrain: begin
            if (i_swap_req) begin
               pend_d = 1'b1;
            end
            if (fifo_empty) begin
               state_d = StClear;
            end
         end
         StClear: begin
            if (i_swap_req) begin
               pend_d = 1'b1;
            end
            if (i_mem_gnt) begin
               if (clr_cnt_q == ADDR_WIDTH'(PIXELS - 1)) begin
                  state_d    = StRun;
                  clr_done_d = 1'b1;
               end else begin
                  clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
`endif
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         front_q <= '0;
         back_q  <= IDX_W'(1);
         pend_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         front_q <= front_d;
         back_q  <= back_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
      end
   end

`ifdef FB_CLEAR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_color_q <= '0;
         clr_cnt_q   <= '0;
         clr_done_q  <= 1'b0;
      end else begin
         clr_color_q <= clr_color_d;
         clr_cnt_q   <= clr_cnt_d;
         clr_done_q  <= clr_done_d;
      end
   end

   assign o_clear_done = clr_done_q;
`endif

   always_comb begin
      o_mem_req   = !fifo_empty;
      o_mem_addr  = fifo_empty ? '0 : head.addr;
      o_mem_wdata = fifo_empty ? '0 : head.color;
`ifdef FB_CLEAR_EN
      if (state_q == StClear) begin
         o_mem_req   = 1'b1;
         o_mem_addr  = back_base + clr_cnt_q;
         o_mem_wdata = clr_color_q;
      end
`endif
   end

   assign o_swap_done  = (state_q == StSwap);
   assign o_front_idx  = front_q;
   assign o_busy       = (fifo_count != '0) || (state_q != StRun);
   assign o_drop_count = drop_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: a queue model of the write stream and buffer rotation is compared
// every cycle, plus directed literal checks; a 3-buffer instance checks rotation order.
module tb_framebuffer_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid, pix_ready;
   logic [9:0]  pix_x, pix_y;
   logic [31:0] pix_color;
   logic        swap_req, swap_done;
   logic [0:0]  front_idx;
   logic        mem_req, mem_gnt;
   logic [19:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic [15:0] drop_count;

   logic        v3, r3, sw3, sd3, mreq3, g3, busy3;
   logic [9:0]  x3, y3;
   logic [31:0] c3, mwd3;
   logic [1:0]  f3;
   logic [19:0] maddr3;
   logic [15:0] drop3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

`ifdef FB_CLEAR_EN
   logic        cd_main, cd_3;
   logic        rst_c, cr, cdone_c, rdy_c, sd_c, mreq_c, gc, busy_c;
   logic [31:0] ccol, mwd_c;
   logic [0:0]  f_c;
   logic [19:0] maddr_c;
   logic [15:0] drop_c;
`endif

   framebuffer_writer dut (
      .clk          (clk),
      .rst          (rst),
      .i_pix_valid  (pix_valid),
      .o_pix_ready  (pix_ready),
      .i_pix_x      (pix_x),
      .i_pix_y      (pix_y),
      .i_pix_color  (pix_color),
      .i_swap_req   (swap_req),
      .o_swap_done  (swap_done),
      .o_front_idx  (front_idx),
      .o_mem_req    (mem_req),
      .i_mem_gnt    (mem_gnt),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
`ifdef FB_CLEAR_EN
      .i_clear_req  (1'b0),
      .i_clear_color(32'h0),
      .o_clear_done (cd_main),
`endif
      .o_busy       (busy),
      .o_drop_count (drop_count)
   );

   framebuffer_writer #(.NUM_BUFFERS(3)) dut3 (
      .clk          (clk),
      .rst          (rst),
      .i_pix_valid  (v3),
      .o_pix_ready  (r3),
      .i_pix_x      (x3),
      .i_pix_y      (y3),
      .i_pix_color  (c3),
      .i_swap_req   (sw3),
      .o_swap_done  (sd3),
      .o_front_idx  (f3),
      .o_mem_req    (mreq3),
      .i_mem_gnt    (g3),
      .o_mem_addr   (maddr3),
      .o_mem_wdata  (mwd3),
`ifdef FB_CLEAR_EN
      .i_clear_req  (1'b0),
      .i_clear_color(32'h0),
      .o_clear_done (cd_3),
`endif
      .o_busy       (busy3),
      .o_drop_count (drop3)
   );

`ifdef FB_CLEAR_EN
   framebuffer_writer #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2)) dutc (
      .clk          (clk),
      .rst          (rst_c),
      .i_pix_valid  (1'b0),
      .o_pix_ready  (rdy_c),
      .i_pix_x      (10'd0),
      .i_pix_y      (10'd0),
      .i_pix_color  (32'h0),
      .i_swap_req   (1'b0),
      .o_swap_done  (sd_c),
      .o_front_idx  (f_c),
      .o_mem_req    (mreq_c),
      .i_mem_gnt    (gc),
      .o_mem_addr   (maddr_c),
      .o_mem_wdata  (mwd_c),
      .i_clear_req  (cr),
      .i_clear_color(ccol),
      .o_clear_done (cdone_c),
      .o_busy       (busy_c),
      .o_drop_count (drop_c)
   );
`endif

   // Model of the main instance: pending writes, buffer indices, drop count, swap progress.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] color;
   } wr_t;

   wr_t         mq[$];
   int unsigned m_front, m_back, m_drops;
   bit          m_swapping, m_swap_now, m_pend;
   bit          m_valid = 1'b0;

   function automatic bit m_ready();
      return !rst && !m_swapping && !m_swap_now && (mq.size() < 8);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int sz;
      bit acc;
      if (rst) begin
         mq.delete();
         m_front    = 0;
         m_back     = 1;
         m_drops    = 0;
         m_swapping = 1'b0;
         m_swap_now = 1'b0;
         m_pend     = 1'b0;
         m_valid    = 1'b1;
      end else if (m_valid) begin
         sz  = mq.size();
         acc = pix_valid && m_ready();
         if (sz != 0 && mem_gnt) void'(mq.pop_front());
         if (acc) begin
            if (pix_x >= 640 || pix_y >= 480) begin
               if (m_drops < 65535) m_drops++;
            end else begin
               mq.push_back('{addr: m_back * 307200 + pix_y * 640 + pix_x, color: pix_color});
            end
         end
         if (m_swap_now) begin
            m_front    = m_back;
            m_back     = (m_back + 1) % 2;
            m_swap_now = 1'b0;
            if (swap_req) m_pend = 1'b1;
         end else if (m_swapping) begin
            if (swap_req) m_pend = 1'b1;
            if (sz == 0) begin
               m_swapping = 1'b0;
               m_swap_now = 1'b1;
            end
         end else if (swap_req || m_pend) begin
            m_swapping = 1'b1;
            m_pend     = 1'b0;
         end
      end
   endtask

   task automatic compare();
      chk("ready", pix_ready, m_ready());
      chk("mem_req", mem_req, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("mem_addr", mem_addr, mq[0].addr);
         chk("mem_wdata", mem_wdata, mq[0].color);
      end
      chk("swap_done", swap_done, m_swap_now);
      chk("front_idx", front_idx, m_front);
      chk("busy", busy, (mq.size() != 0) || m_swapping || m_swap_now);
      chk("drop_count", drop_count, m_drops);
   endtask

   always @(negedge clk) begin
      if (m_valid) compare();
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      int acc, pops, done, n;
      bit rdy;
      rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
      swap_req = 1'b0; mem_gnt = 1'b0;
      v3 = 1'b0; x3 = '0; y3 = '0; c3 = '0; sw3 = 1'b0; g3 = 1'b0;
`ifdef FB_CLEAR_EN
      rst_c = 1'b1; cr = 1'b0; ccol = '0; gc = 1'b0;
`endif
      cyc(); cyc();
      chk("rst_ready", pix_ready, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_swap_done", swap_done, 0);
      chk("rst_front", front_idx, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // Single pixel with grant held: visible next cycle, gone the one after.
      mem_gnt = 1'b1; pix_valid = 1'b1; pix_x = 10'd3; pix_y = 10'd2; pix_color = 32'hDEADBEEF;
      cyc();
      pix_valid = 1'b0;
      chk("t1_req", mem_req, 1);
      chk("t1_addr", mem_addr, 308483);
      chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
      cyc();
      chk("t1_popped", mem_req, 0);

      // Fill with grant low, then drain.
      mem_gnt = 1'b0; acc = 0;
      for (int k = 0; k < 12; k++) begin
         pix_valid = 1'b1; pix_x = 10'(acc); pix_y = '0; pix_color = 32'h100 + acc;
         rdy = pix_ready;
         cyc();
         if (rdy) acc++;
      end
      pix_valid = 1'b0;
      chk("t2_accepts", acc, 8);
      chk("t2_ready_full", pix_ready, 0);
      cyc(); cyc();
      chk("t2_head_addr", mem_addr, 307200);
      chk("t2_head_data", mem_wdata, 32'h100);
      mem_gnt = 1'b1; pops = 0;
      for (int k = 0; k < 20 && mem_req; k++) begin
         cyc();
         pops++;
      end
      chk("t2_pops", pops, 8);

      // Streaming with grant high: push and pop in the same cycle.
      for (int k = 0; k < 5; k++) begin
         pix_valid = 1'b1; pix_x = 10'(20 + k); pix_y = 10'd5; pix_color = 32'h200 + k;
         cyc();
      end
      pix_valid = 1'b0;
      cyc(); cyc();

      // Clipping and drop-count saturation.
      pix_valid = 1'b1; pix_x = 10'd640; pix_y = 10'd0;
      cyc();
      pix_x = 10'd0; pix_y = 10'd480;
      cyc();
      pix_valid = 1'b0;
      cyc();
      chk("t3_drops", drop_count, 2);
      chk("t3_no_req", mem_req, 0);
      pix_valid = 1'b1; pix_x = 10'd640; pix_y = 10'd0;
      repeat (65533) cyc();
      chk("t3_sat", drop_count, 16'hFFFF);
      repeat (4) cyc();
      pix_valid = 1'b0;
      cyc();
      chk("t3_sat_hold", drop_count, 16'hFFFF);

      // Swap with four pending writes.
      mem_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pix_valid = 1'b1; pix_x = 10'(10 + k); pix_y = 10'd1; pix_color = 32'h400 + k;
         cyc();
      end
      pix_valid = 1'b0; swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      chk("t4_ready_drain", pix_ready, 0);
      chk("t4_busy", busy, 1);
      cyc(); cyc();
      chk("t4_ready_wait", pix_ready, 0);
      mem_gnt = 1'b1; done = 0;
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (swap_done) done++;
      end
      chk("t4_done_once", done, 1);
      chk("t4_front", front_idx, 1);
      mem_gnt = 1'b0; pix_valid = 1'b1; pix_x = '0; pix_y = '0; pix_color = 32'hABC;
      cyc();
      pix_valid = 1'b0;
      chk("t4_addr0", mem_addr, 0);
      chk("t4_data", mem_wdata, 32'hABC);
      mem_gnt = 1'b1;
      cyc();

      // Reset mid-operation discards queued writes and rotation.
      mem_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pix_valid = 1'b1; pix_x = 10'(k); pix_y = 10'd7; pix_color = 32'h500 + k;
         cyc();
      end
      pix_valid = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst2_req", mem_req, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_front", front_idx, 0);

      // Swap from empty FIFO completes two cycles after the request.
      swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      chk("t4_early", swap_done, 0);
      cyc();
      chk("t4_two_cycle", swap_done, 1);
      cyc();
      chk("t4_front_after", front_idx, 1);

      // Three-buffer rotation order 1, 2, 0.
      for (int k = 0; k < 3; k++) begin
         sw3 = 1'b1;
         cyc();
         sw3 = 1'b0;
         cyc(); cyc();
         chk("t5_front", f3, (k + 1) % 3);
      end
      // Requests during drain merge into one extra swap.
      g3 = 1'b0; v3 = 1'b1; x3 = '0; y3 = '0; c3 = 32'h77;
      cyc();
      v3 = 1'b0;
      chk("t5_addr", maddr3, 307200);
      chk("t5_data", mwd3, 32'h77);
      chk("t5_busy", busy3, 1);
      sw3 = 1'b1;
      cyc(); cyc(); cyc();
      sw3 = 1'b0;
      chk("t5_ready_drain", r3, 0);
      g3 = 1'b1; done = 0;
      for (int k = 0; k < 15; k++) begin
         cyc();
         if (sd3) done++;
      end
      chk("t5_done_count", done, 2);
      chk("t5_front_final", f3, 2);
      chk("t5_drops", drop3, 0);

`ifdef FB_CLEAR_EN
      rst_c = 1'b0; gc = 1'b1;
      chk("t6_rst_ready", rdy_c, 1);
      chk("t6_rst_front", f_c, 0);
      cr = 1'b1; ccol = 32'h55;
      cyc();
      cr = 1'b0; ccol = 32'h0;
      n = 0; done = 0;
      for (int k = 0; k < 20; k++) begin
         if (mreq_c) begin
            chk("t6_addr", maddr_c, 8 + n);
            chk("t6_data", mwd_c, 32'h55);
            n++;
         end
         cyc();
         if (cdone_c) done++;
      end
      chk("t6_writes", n, 8);
      chk("t6_done", done, 1);
      chk("t6_swap_idle", sd_c, 0);
      chk("t6_drop", drop_c, 0);
      cr = 1'b1; ccol = 32'h66;
      cyc();
      cr = 1'b0;
      cyc(); cyc(); cyc();
      chk("t6_mid_req", mreq_c, 1);
      rst_c = 1'b1;
      cyc();
      rst_c = 1'b0;
      chk("t6_rst_req", mreq_c, 0);
      chk("t6_rst_busy", busy_c, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
